// File: rtl/memory_bus_responder.sv
// MemoryBus target: accepts read/write request packets, services them against a
// word-addressed store and returns read responses after a fixed latency.
module memory_bus_responder #(
  parameter int ADDR_W       = 32,
  parameter int PAYLOAD_W    = 64,
  parameter int BUSID_W      = 4,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_busy,
  input  logic [1:0]           req_type,
  input  logic [BUSID_W-1:0]   req_source,
  input  logic [ADDR_W-1:0]    req_address,
  input  logic [PAYLOAD_W-1:0] req_payload,
  output logic                 req_accept,
  input  logic                 resp_busy,
  output logic                 resp_send,
  output logic [BUSID_W-1:0]   resp_source,
  output logic [PAYLOAD_W-1:0] resp_payload,
  output logic [ADDR_W-1:0]    resp_address,
  output logic [1:0]           resp_type,
  output logic                 error
);
  localparam int BYTE_SH = $clog2(PAYLOAD_W / 8);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int CNT_W   = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam bit FAST_READ = (READ_LATENCY == 1);
  // The LAT->RESP edge itself is one latency cycle and RESP->send is another.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

  typedef enum logic [2:0] {IDLE, LAT, RESP, WRITE, BADTYPE, DRAIN} state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 accept_next, send_next, error_next;
  logic                 capture, load_rd, do_write;
  logic [IDX_W-1:0]     idx;
  logic                 in_range;
  logic [PAYLOAD_W-1:0] wdata;
  logic [PAYLOAD_W-1:0] store [DEPTH];

  logic [ADDR_W-1:0]    full_idx;
  logic [IDX_W-1:0]     req_idx, rd_idx;
  logic                 req_in_range, rd_ok;

  assign full_idx     = req_address >> BYTE_SH;
  assign req_in_range = full_idx < ADDR_W'(DEPTH);
  assign req_idx      = full_idx[IDX_W-1:0];
  // A single-cycle read loads straight from the incoming request.
  assign rd_idx       = (state == IDLE) ? req_idx : idx;
  assign rd_ok        = (state == IDLE) ? req_in_range : in_range;

  assign resp_address = '0;
  assign resp_type    = 2'd2;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    accept_next = 1'b0;
    send_next   = 1'b0;
    error_next  = 1'b0;
    capture     = 1'b0;
    load_rd     = 1'b0;
    do_write    = 1'b0;
    unique case (state)
      IDLE: if (req_busy) begin
        accept_next = 1'b1;
        capture     = 1'b1;
        unique case (req_type)
          2'd0: begin
            if (FAST_READ) begin
              state_next = RESP;
              load_rd    = 1'b1;
              error_next = !req_in_range;
            end else begin
              state_next = LAT;
              cnt_next   = CNT_INIT;
            end
          end
          2'd1:    state_next = WRITE;
          default: state_next = BADTYPE;
        endcase
      end
      LAT: begin
        if (cnt == '0) begin
          state_next = RESP;
          load_rd    = 1'b1;
          error_next = !in_range;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: if (!resp_busy) begin
        send_next  = 1'b1;
        state_next = IDLE;
      end
      WRITE: begin
        do_write   = in_range && !reset;
        error_next = !in_range;
        state_next = DRAIN;
      end
      BADTYPE: begin
        error_next = 1'b1;
        state_next = DRAIN;
      end
      // req_busy may still read high here because the bus clears it a cycle late.
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      req_accept   <= 1'b0;
      resp_send    <= 1'b0;
      error        <= 1'b0;
      resp_source  <= '0;
      resp_payload <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      req_accept <= accept_next;
      resp_send  <= send_next;
      error      <= error_next;
      if (capture) resp_source  <= req_source;
      if (load_rd) resp_payload <= rd_ok ? store[rd_idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      idx      <= req_idx;
      in_range <= req_in_range;
      wdata    <= req_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) store[idx] <= wdata;
  end

endmodule
